// File: rtl/qupls_mem_issue_sched.sv
// Memory issue scheduler: scans a window of ROB slots from head, picks ready
// loads/stores oldest-first and hands them to free memory issue ports.
package qupls_mem_issue_sched_pkg;
   localparam int ROB_ENTRIES = 16;
   localparam int PADR_W      = 32;
   typedef logic [3:0]             rob_ndx_t;
   typedef logic [ROB_ENTRIES-1:0] rob_bitmask_t;
   typedef struct packed {
      logic        load;
      logic        store;
      logic        fence;
      logic        fc;
      logic [31:0] immb;
   } decbus_t;
   typedef struct packed {
      logic              v;
      logic [7:0]        sn;
      logic              argA_v;
      logic              argB_v;
      logic              argC_v;
      logic              done;
      logic              out;
      logic              tlb;
      logic              agen;
      logic [PADR_W-1:0] padr;
      decbus_t           decbus;
   } rob_entry_t;
endpackage

module qupls_mem_issue_sched
   import qupls_mem_issue_sched_pkg::*;
#(
   parameter int WINDOW_SIZE = 12,
   parameter int NPORTS      = 2,
   parameter int MAX_STORES  = 1,
   parameter int OVL_SHIFT   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  rob_ndx_t          head,
   input  rob_bitmask_t      robentry_stomp,
   input  rob_bitmask_t      rob_v,
   input  rob_entry_t        rob [ROB_ENTRIES],
   input  logic [NPORTS-1:0] port_ack,
   output rob_bitmask_t      robentry_memissue,
   output rob_ndx_t          ndx [NPORTS],
   output logic [NPORTS-1:0] ndxv
);

   rob_bitmask_t      memissue_q, memissue_d;
   rob_ndx_t          ndx_q [NPORTS];
   rob_ndx_t          ndx_d [NPORTS];
   logic [NPORTS-1:0] ndxv_q, ndxv_d;

   rob_ndx_t          hd [WINDOW_SIZE];
   rob_ndx_t          chosen [NPORTS];
   rob_bitmask_t      held, set_mask;
   logic [NPORTS-1:0] kill, free;
   int unsigned       nfree, nsel, nst, asg;
   logic              elig, blk;
   rob_ndx_t          c, hj;
   logic              unused_bits;

   always_comb begin
      held        = '0;
      set_mask    = '0;
      kill        = '0;
      free        = '0;
      nfree       = 0;
      nsel        = 0;
      nst         = 0;
      asg         = 0;
      elig        = 1'b0;
      blk         = 1'b0;
      c           = '0;
      hj          = '0;
      unused_bits = 1'b0;
      for (int unsigned k = 0; k < NPORTS; k++) begin
         chosen[k] = '0;
         ndx_d[k]  = ndx_q[k];
      end
      ndxv_d = ndxv_q;
      for (int unsigned n = 0; n < ROB_ENTRIES; n++)
         unused_bits = unused_bits ^ (^{rob[n].v, rob[n].padr[OVL_SHIFT-1:0], rob[n].decbus.immb[31:16]});
      for (int unsigned i = 0; i < WINDOW_SIZE; i++)
         hd[i] = rob_ndx_t'((32'(head) + i) % ROB_ENTRIES);

      // A held slot that is squashed or retired frees its port regardless of ack.
      for (int unsigned k = 0; k < NPORTS; k++) begin
         if (ndxv_q[k]) held[ndx_q[k]] = 1'b1;
         kill[k] = ndxv_q[k] && (robentry_stomp[ndx_q[k]] || !rob_v[ndx_q[k]]);
         free[k] = !ndxv_q[k] || port_ack[k] || kill[k];
         if (free[k]) nfree++;
      end

      for (int unsigned i = 0; i < WINDOW_SIZE; i++) begin
         c    = hd[i];
         elig = rob_v[c] && rob[c].argA_v && rob[c].argB_v &&
                (rob[c].decbus.load || rob[c].argC_v) && rob[c].tlb &&
                !rob[c].done && !rob[c].out && !robentry_stomp[c] &&
                !memissue_q[c] && !held[c];
         blk  = 1'b0;
         if (i > 0) begin
            for (int unsigned j = 0; j < WINDOW_SIZE; j++) begin
               hj = hd[j];
               if (rob_v[hj] && rob[hj].sn < rob[c].sn) begin
                  if (rob[hj].decbus.fence && rob[hj].decbus.immb[15:0] == 16'hFF00) blk = 1'b1;
                  if (rob[hj].decbus.fc && rob[c].decbus.store) blk = 1'b1;
                  if ((rob[hj].decbus.load || rob[hj].decbus.store) && !rob[hj].agen) blk = 1'b1;
                  if (rob[hj].padr[PADR_W-1:OVL_SHIFT] == rob[c].padr[PADR_W-1:OVL_SHIFT]) blk = 1'b1;
               end
            end
         end
         if (rob[c].decbus.store && nst >= MAX_STORES) blk = 1'b1;
         if (elig && !blk && nsel < nfree) begin
            chosen[nsel] = c;
            nsel++;
            if (rob[c].decbus.store) nst++;
            set_mask[c] = 1'b1;
         end
      end

      for (int unsigned k = 0; k < NPORTS; k++) begin
         if (free[k] && asg < nsel) begin
            ndx_d[k]  = chosen[asg];
            ndxv_d[k] = 1'b1;
            asg++;
         end else if (free[k]) begin
            ndxv_d[k] = 1'b0;
         end
      end

      for (int unsigned n = 0; n < ROB_ENTRIES; n++)
         memissue_d[n] = (!rob_v[n] || robentry_stomp[n]) ? 1'b0 : (memissue_q[n] | set_mask[n]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         memissue_q <= '0;
         ndxv_q     <= '0;
         for (int unsigned k = 0; k < NPORTS; k++) ndx_q[k] <= '0;
      end else begin
         memissue_q <= memissue_d;
         ndxv_q     <= ndxv_d;
         for (int unsigned k = 0; k < NPORTS; k++) ndx_q[k] <= ndx_d[k];
      end
   end

   assign robentry_memissue = memissue_q;
   assign ndxv              = ndxv_q;
   always_comb begin
      for (int unsigned k = 0; k < NPORTS; k++) ndx[k] = ndx_q[k];
   end

endmodule

// File: tb/tb_qupls_mem_issue_sched.sv
// Directed bench for qupls_mem_issue_sched: inputs driven on negedge, outputs
// checked on the following negedge against hand-computed values.
module tb_qupls_mem_issue_sched;
   import qupls_mem_issue_sched_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   rob_ndx_t     head;
   rob_bitmask_t robentry_stomp;
   rob_bitmask_t rob_v;
   rob_entry_t   rob [ROB_ENTRIES];
   logic [1:0]   port_ack;
   rob_bitmask_t robentry_memissue;
   rob_ndx_t     ndx [2];
   logic [1:0]   ndxv;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   qupls_mem_issue_sched #(
      .WINDOW_SIZE(12),
      .NPORTS(2),
      .MAX_STORES(1),
      .OVL_SHIFT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .head(head),
      .robentry_stomp(robentry_stomp),
      .rob_v(rob_v),
      .rob(rob),
      .port_ack(port_ack),
      .robentry_memissue(robentry_memissue),
      .ndx(ndx),
      .ndxv(ndxv)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mk(input int s, input logic [7:0] sn, input logic [31:0] pa, input logic st);
      rob[s]               = '0;
      rob[s].v             = 1'b1;
      rob[s].sn            = sn;
      rob[s].argA_v        = 1'b1;
      rob[s].argB_v        = 1'b1;
      rob[s].argC_v        = 1'b1;
      rob[s].tlb           = 1'b1;
      rob[s].agen          = 1'b1;
      rob[s].padr          = pa;
      rob[s].decbus.load   = !st;
      rob[s].decbus.store  = st;
      rob_v[s]             = 1'b1;
   endtask

   initial begin
      rst            = 1'b1;
      head           = '0;
      robentry_stomp = '0;
      rob_v          = '0;
      port_ack       = '0;
      for (int n = 0; n < ROB_ENTRIES; n++) rob[n] = '0;

      // reset with ready loads present: nothing issues
      mk(0, 8'd1, 32'h100, 1'b0);
      mk(1, 8'd2, 32'h200, 1'b0);
      tick(); tick();
      chk("rst_ndxv", 32'(ndxv), 32'h0);
      chk("rst_mem", 32'(robentry_memissue), 32'h0);
      chk("rst_ndx0", 32'(ndx[0]), 32'h0);
      chk("rst_ndx1", 32'(ndx[1]), 32'h0);

      // two loads issue to both ports one cycle after reset release
      rst = 1'b0;
      tick();
      chk("two_ndx0", 32'(ndx[0]), 32'd0);
      chk("two_ndx1", 32'(ndx[1]), 32'd1);
      chk("two_ndxv", 32'(ndxv), 32'h3);
      chk("two_mem", 32'(robentry_memissue), 32'h0003);
      tick();
      chk("hold_ndx1", 32'(ndx[1]), 32'd1);
      port_ack = 2'b11; rob_v[0] = 1'b0; rob_v[1] = 1'b0;
      tick();
      port_ack = 2'b00;
      chk("ret_ndxv", 32'(ndxv), 32'h0);
      chk("ret_mem", 32'(robentry_memissue), 32'h0);

      // two stores, one store per cycle
      mk(3, 8'd3, 32'h300, 1'b1);
      mk(4, 8'd4, 32'h400, 1'b1);
      tick();
      chk("st_ndx0", 32'(ndx[0]), 32'd3);
      chk("st_ndxv", 32'(ndxv), 32'h1);
      chk("st_mem", 32'(robentry_memissue), 32'h0008);
      port_ack = 2'b01;
      tick();
      port_ack = 2'b00;
      chk("st2_ndx0", 32'(ndx[0]), 32'd4);
      chk("st2_ndxv", 32'(ndxv), 32'h1);
      chk("st2_mem", 32'(robentry_memissue), 32'h0018);
      port_ack = 2'b01; rob_v[3] = 1'b0; rob_v[4] = 1'b0;
      tick();
      port_ack = 2'b00;
      chk("st_clr", 32'(ndxv), 32'h0);

      // window wraps from slot 15 to slot 0
      head = 4'd14;
      mk(15, 8'd10, 32'hF00, 1'b0);
      mk(0, 8'd11, 32'h050, 1'b0);
      tick();
      chk("wrap_ndx0", 32'(ndx[0]), 32'd15);
      chk("wrap_ndx1", 32'(ndx[1]), 32'd0);
      chk("wrap_ndxv", 32'(ndxv), 32'h3);
      chk("wrap_mem", 32'(robentry_memissue), 32'h8001);
      port_ack = 2'b11; rob_v[15] = 1'b0; rob_v[0] = 1'b0;
      tick();
      port_ack = 2'b00;
      chk("wrap_clr", 32'(ndxv), 32'h0);

      // port 0 stalls with slot 2 while slot 5 waits, then back-to-back reload
      head = 4'd0;
      mk(2, 8'd2, 32'h220, 1'b0);
      mk(3, 8'd3, 32'h330, 1'b0);
      tick();
      chk("stall_ndxv", 32'(ndxv), 32'h3);
      mk(5, 8'd5, 32'h550, 1'b0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("stall_ndx0", 32'(ndx[0]), 32'd2);
         chk("stall_mem", 32'(robentry_memissue), 32'h000C);
      end
      port_ack = 2'b01;
      tick();
      port_ack = 2'b00;
      chk("b2b_ndx0", 32'(ndx[0]), 32'd5);
      chk("b2b_ndx1", 32'(ndx[1]), 32'd3);
      chk("b2b_ndxv", 32'(ndxv), 32'h3);
      chk("b2b_mem", 32'(robentry_memissue), 32'h002C);
      port_ack = 2'b11; rob_v[2] = 1'b0; rob_v[3] = 1'b0; rob_v[5] = 1'b0;
      tick();
      port_ack = 2'b00;
      chk("b2b_clr", 32'(ndxv), 32'h0);

      // older load without agen blocks, then padr overlap keeps blocking
      mk(1, 8'd1, 32'h180, 1'b0);
      rob[1].agen = 1'b0; rob[1].tlb = 1'b0;
      mk(2, 8'd2, 32'h280, 1'b0);
      tick();
      chk("agen_blk", 32'(ndxv), 32'h0);
      tick();
      chk("agen_blk2", 32'(robentry_memissue), 32'h0);
      rob[1].agen = 1'b1; rob[1].padr = 32'h28C;
      tick();
      chk("ovl_blk", 32'(ndxv), 32'h0);
      rob[1].padr = 32'h180;
      tick();
      chk("agen_ndx0", 32'(ndx[0]), 32'd2);
      chk("agen_ndxv", 32'(ndxv), 32'h1);
      chk("agen_mem", 32'(robentry_memissue), 32'h0004);
      port_ack = 2'b01; rob_v[1] = 1'b0; rob_v[2] = 1'b0;
      tick();
      port_ack = 2'b00;

      // stomp with simultaneous ack clears the port and the sticky bit
      mk(6, 8'd6, 32'h660, 1'b0);
      tick();
      chk("stomp_pre", 32'(ndx[0]), 32'd6);
      chk("stomp_mem0", 32'(robentry_memissue), 32'h0040);
      robentry_stomp[6] = 1'b1; port_ack = 2'b01;
      tick();
      robentry_stomp[6] = 1'b0; port_ack = 2'b00; rob_v[6] = 1'b0;
      chk("stomp_ndxv", 32'(ndxv), 32'h0);
      chk("stomp_mem", 32'(robentry_memissue), 32'h0);

      // reset mid-issue discards held ports, issue resumes afterwards
      mk(7, 8'd7, 32'h770, 1'b0);
      mk(8, 8'd8, 32'h880, 1'b0);
      tick();
      chk("mid_ndxv", 32'(ndxv), 32'h3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_ndxv", 32'(ndxv), 32'h0);
      chk("mid_rst_ndx0", 32'(ndx[0]), 32'h0);
      chk("mid_rst_ndx1", 32'(ndx[1]), 32'h0);
      chk("mid_rst_mem", 32'(robentry_memissue), 32'h0);
      tick();
      chk("resume_ndx0", 32'(ndx[0]), 32'd7);
      chk("resume_ndx1", 32'(ndx[1]), 32'd8);
      chk("resume_mem", 32'(robentry_memissue), 32'h0180);
      port_ack = 2'b11; rob_v[7] = 1'b0; rob_v[8] = 1'b0;
      tick();
      port_ack = 2'b00;

      // older fence with immb FF00 blocks a younger load
      rob[9]              = '0;
      rob[9].v            = 1'b1;
      rob[9].sn           = 8'd9;
      rob[9].padr         = 32'h990;
      rob[9].decbus.fence = 1'b1;
      rob[9].decbus.immb  = 32'h0000FF00;
      rob_v[9]            = 1'b1;
      mk(10, 8'd10, 32'hAA0, 1'b0);
      tick();
      chk("fence_blk", 32'(ndxv), 32'h0);
      rob[9].decbus.immb = 32'h0;
      tick();
      chk("fence_ndx0", 32'(ndx[0]), 32'd10);
      chk("fence_ndxv", 32'(ndxv), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
